// File: rtl/ln_param_streamer_if.sv
// Bundles the streamer's two buses so they travel together:
// - SRAM read side: rd_en, rd_addr, gamma_rd_data, beta_rd_data.
// - Consumer side: out_gamma, out_beta, out_vld, out_last, out_ready.
// master = streamer side, slave = SRAM model plus consumer side.
//
// Output handshake: a word moves when |out_vld && out_ready on a rising clk.
// While a word is offered and not taken, all out_* fields stay unchanged.
// out_ready may toggle freely and has no effect while out_vld is zero.
interface ln_param_streamer_if #(
  parameter int BUS_NUM    = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int W          = 16
);
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [BUS_NUM*W-1:0]    gamma_rd_data;
  logic [BUS_NUM*W-1:0]    beta_rd_data;
  logic [BUS_NUM*W-1:0]    out_gamma;
  logic [BUS_NUM*W-1:0]    out_beta;
  logic [BUS_NUM-1:0]      out_vld;
  logic                    out_last;
  logic                    out_ready;

  modport master (
    output rd_en, rd_addr, out_gamma, out_beta, out_vld, out_last,
    input  gamma_rd_data, beta_rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_gamma, out_beta, out_vld, out_last,
    output gamma_rd_data, beta_rd_data, out_ready
  );
endinterface

// File: rtl/ln_param_streamer.sv
// Streams per-channel LayerNorm gamma/beta words out of two parameter SRAMs.
// - Reads are issued against a 2-credit budget, so the FIFO plus the read in
//   flight never hold more than two words.
// - Each word lands in a 2-entry skid FIFO together with its lane mask and
//   last flag, both decided when the read is issued.
// - state_dbg exposes the FSM state for observation.
module ln_param_streamer #(
  parameter int BUS_NUM        = 8,
  parameter int DATA_NUM_WIDTH = 10,
  parameter int ADDR_WIDTH     = 8,
  parameter int sig_width      = 7,
  parameter int exp_width      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DATA_NUM_WIDTH-1:0] in_data_num,
  input  logic [ADDR_WIDTH-1:0]     in_base_addr,
  ln_param_streamer_if.master       bus,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                state_dbg
);
  localparam int W  = sig_width + exp_width + 1;
  localparam int BW = BUS_NUM * W;
  localparam int LB = $clog2(BUS_NUM);
  localparam int RW = LB + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_nxt;

  logic [DATA_NUM_WIDTH-1:0] n_words_q, issue_idx, n_words_calc;
  logic [RW-1:0]             rem_q, rem_calc;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [1:0]                credits;
  logic                      pend_vld, pend_last;
  logic [BUS_NUM-1:0]        pend_mask, issue_mask;
  logic [BW-1:0]             fifo_g [2];
  logic [BW-1:0]             fifo_b [2];
  logic [BUS_NUM-1:0]        fifo_m [2];
  logic                      fifo_l [2];
  logic                      rd_ptr, wr_ptr;
  logic [1:0]                fifo_cnt;
  logic                      start_ok, issue, last_issue, pop, head_last;
  logic [LB-1:0]             low_bits;
  logic [BW-1:0]             wr_g, wr_b;

  // Word count is a ceiling divide by the (power-of-two) lane count; the
  // final word carries rem lanes, which is BUS_NUM when the count divides evenly.
  assign low_bits     = in_data_num[LB-1:0];
  assign n_words_calc = (in_data_num >> LB) + DATA_NUM_WIDTH'(low_bits != '0);
  assign rem_calc     = (low_bits == '0) ? RW'(BUS_NUM) : {1'b0, low_bits};

  assign start_ok   = (state == IDLE) && start && (in_data_num != '0);
  assign last_issue = (issue_idx == n_words_q - DATA_NUM_WIDTH'(1));
  assign pop        = (fifo_cnt != 2'd0) && bus.out_ready;
  assign head_last  = fifo_l[rd_ptr];
  // A pop in the same cycle frees a slot, so an issue may reuse it at once.
  assign issue      = (state == FETCH) && ((credits != 2'd0) || pop);

  assign bus.rd_en     = issue;
  assign bus.rd_addr   = issue ? (base_q + ADDR_WIDTH'(issue_idx)) : '0;
  assign bus.out_gamma = (fifo_cnt != 2'd0) ? fifo_g[rd_ptr] : '0;
  assign bus.out_beta  = (fifo_cnt != 2'd0) ? fifo_b[rd_ptr] : '0;
  assign bus.out_vld   = (fifo_cnt != 2'd0) ? fifo_m[rd_ptr] : '0;
  assign bus.out_last  = (fifo_cnt != 2'd0) ? fifo_l[rd_ptr] : 1'b0;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;

  // Lane mask for the word being issued: only the final word is partial.
  always_comb begin
    issue_mask = '1;
    if (last_issue) begin
      for (int i = 0; i < BUS_NUM; i++) issue_mask[i] = (RW'(i) < rem_q);
    end
  end

  // Zero the lanes beyond the mask as the SRAM data enters the FIFO.
  always_comb begin
    wr_g = bus.gamma_rd_data;
    wr_b = bus.beta_rd_data;
    for (int i = 0; i < BUS_NUM; i++) begin
      if (!pend_mask[i]) begin
        wr_g[i*W +: W] = '0;
        wr_b[i*W +: W] = '0;
      end
    end
  end

  // Next-state logic: IDLE -> FETCH on a non-empty start, FETCH -> DRAIN after
  // the final read, DRAIN -> IDLE once the final word has been taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = FETCH;
      FETCH:   if (issue && last_issue) state_nxt = DRAIN;
      DRAIN:   if (pop && head_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Row parameters latch on an accepted start; the issue index then advances per read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words_q <= '0;
      rem_q     <= '0;
      base_q    <= '0;
      issue_idx <= '0;
    end else if (start_ok) begin
      n_words_q <= n_words_calc;
      rem_q     <= rem_calc;
      base_q    <= in_base_addr;
      issue_idx <= '0;
    end else if (issue) begin
      issue_idx <= issue_idx + DATA_NUM_WIDTH'(1);
    end
  end

  // Credits: an issue spends one and a pop returns one; both together cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= 2'd2;
    end else begin
      case ({issue, pop})
        2'b10:   credits <= credits - 2'd1;
        2'b01:   credits <= credits + 2'd1;
        default: credits <= credits;
      endcase
    end
  end

  // The read in flight carries its mask and last flag until the SRAM data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_last <= 1'b0;
      pend_mask <= '0;
    end else begin
      pend_vld  <= issue;
      pend_last <= issue && last_issue;
      pend_mask <= issue_mask;
    end
  end

  // Two-entry skid FIFO: push the returned read and pop on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_g[i] <= '0;
        fifo_b[i] <= '0;
        fifo_m[i] <= '0;
        fifo_l[i] <= 1'b0;
      end
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (pend_vld) begin
        fifo_g[wr_ptr] <= wr_g;
        fifo_b[wr_ptr] <= wr_b;
        fifo_m[wr_ptr] <= pend_mask;
        fifo_l[wr_ptr] <= pend_last;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({pend_vld, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Pulse done in the cycle after the final word's handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done <= 1'b0;
    else        done <= pop && head_last;
  end
endmodule

// File: tb/tb_ln_param_streamer.sv
// Bench for ln_param_streamer.
// - Random parameter SRAM contents; the SRAM returns read data one cycle after
//   rd_en and drives noise otherwise.
// - A row-level reference model queues the expected read addresses and output
//   words, plus the latency, masking, reset and corner cases.
module tb_ln_param_streamer;
  localparam int BUS_NUM = 8;
  localparam int DNW     = 10;
  localparam int AW      = 8;
  localparam int W       = 16;
  localparam int BW      = BUS_NUM * W;
  localparam int EW      = 1 + BUS_NUM + 2 * BW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [DNW-1:0] in_data_num = '0;
  logic [AW-1:0]  in_base_addr = '0;
  logic           busy, done;
  logic [1:0]     state_dbg;

  ln_param_streamer_if #(.BUS_NUM(BUS_NUM), .ADDR_WIDTH(AW), .W(W)) bus ();

  ln_param_streamer #(
    .BUS_NUM(BUS_NUM), .DATA_NUM_WIDTH(DNW), .ADDR_WIDTH(AW),
    .sig_width(7), .exp_width(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_data_num(in_data_num),
    .in_base_addr(in_base_addr),
    .bus(bus),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference state ----------------
  logic [BW-1:0]   mem_g [256];
  logic [BW-1:0]   mem_b [256];
  logic [EW-1:0]   exp_q [$];
  logic [AW-1:0]   addr_q [$];
  int              total = 0;
  int              bad = 0;
  int              issued = 0;
  int              accepted = 0;
  bit              rand_ready = 1'b0;
  bit              done_exp = 1'b0;
  bit              prev_stall = 1'b0;
  logic [EW-1:0]   prev_word;
  logic [EW-1:0]   mon_cur;
  logic [EW-1:0]   mon_exp;
  bit              mon_xfer;

  task automatic check_val(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM model: read data one cycle after rd_en, noise otherwise.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.gamma_rd_data <= mem_g[bus.rd_addr];
      bus.beta_rd_data  <= mem_b[bus.rd_addr];
    end else begin
      bus.gamma_rd_data <= {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.beta_rd_data  <= {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  end

  // Consumer ready: steady high, or random when rand_ready is set.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_ready ? ($urandom_range(0, 99) < 55) : 1'b1;
    end
  end

  // Row model: ceil(n/BUS_NUM) words from consecutive wrapping addresses; the
  // final word keeps its first rem lanes and zeroes the rest.
  task automatic push_row(input int n, input int base);
    int nw;
    int rem;
    int lanes;
    logic [BW-1:0] g;
    logic [BW-1:0] b;
    logic [BUS_NUM-1:0] m;
    nw  = (n + BUS_NUM - 1) / BUS_NUM;
    rem = n - (nw - 1) * BUS_NUM;
    for (int k = 0; k < nw; k++) begin
      lanes = (k == nw - 1) ? rem : BUS_NUM;
      g = mem_g[(base + k) % 256];
      b = mem_b[(base + k) % 256];
      m = '0;
      for (int i = 0; i < BUS_NUM; i++) begin
        if (i < lanes) m[i] = 1'b1;
        else begin
          g[i*W +: W] = '0;
          b[i*W +: W] = '0;
        end
      end
      exp_q.push_back({(k == nw - 1), m, b, g});
      addr_q.push_back(AW'(base + k));
    end
  endtask

  // Scoreboard / monitor on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_exp   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        mon_cur  = {bus.out_last, bus.out_vld, bus.out_beta, bus.out_gamma};
        mon_xfer = (bus.out_vld != '0) && bus.out_ready;
        if (prev_stall) check_val("hold_stable", mon_cur, prev_word);
        check_val("rd_expected", EW'(bus.rd_en && addr_q.size() == 0), '0);
        if (bus.rd_en && addr_q.size() != 0) begin
          check_val("rd_addr", EW'(bus.rd_addr), EW'(addr_q.pop_front()));
          issued++;
        end
        check_val("out_expected", EW'(mon_xfer && exp_q.size() == 0), '0);
        check_val("done", EW'(done), EW'(done_exp));
        done_exp = 1'b0;
        if (mon_xfer && exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_val("out_word", mon_cur, mon_exp);
          done_exp = mon_exp[EW-1];
          accepted++;
        end
        check_val("held_le2", EW'((issued - accepted) <= 2), EW'(1));
        prev_stall = (bus.out_vld != '0) && !bus.out_ready;
        prev_word  = mon_cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_row(input int n, input int base, input bit track, input bit now);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    start        = 1'b1;
    in_data_num  = DNW'(n);
    in_base_addr = AW'(base);
    if (track && n != 0) push_row(n, base);
    @(posedge clk);
    #1;
    start        = 1'b0;
    in_data_num  = DNW'($urandom());
    in_base_addr = AW'($urandom());
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && addr_q.size() == 0) ok = 1'b1;
    end
    check_val("row_complete", EW'(ok), EW'(1));
  endtask

  // Row with out_ready held high: checks first-valid and done latencies.
  task automatic run_timed(input int n, input int base, input bit now);
    int nw;
    int first_vld;
    int done_k;
    nw        = (n + BUS_NUM - 1) / BUS_NUM;
    first_vld = -1;
    done_k    = -1;
    start_row(n, base, 1'b1, now);
    for (int k = 1; k <= 400 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 1) check_val("busy_rise", EW'(busy), EW'(1));
      if (first_vld < 0 && bus.out_vld != '0) first_vld = k;
      if (done) begin
        done_k = k;
        check_val("busy_at_done", EW'(busy), '0);
      end
    end
    check_val("first_vld_lat", EW'(first_vld), EW'(3));
    check_val("done_lat", EW'(done_k), EW'(3 + nw));
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_data"}, EW'({bus.out_beta, bus.out_gamma}), '0);
    check_val({tag, "_ctrl"},
              EW'({bus.rd_en, bus.rd_addr, bus.out_vld, bus.out_last, busy, done}), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int a = 0; a < 256; a++) begin
      mem_g[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_b[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    #1 rst_n = 1'b1;

    // two full words from 0x10
    run_timed(16, 'h10, 1'b0);
    // partial final word
    run_timed(13, $urandom_range(0, 255), 1'b0);
    // address wrap past 0xFF
    run_timed(24, 'hFF, 1'b0);
    // start accepted in the done cycle
    run_timed(8, $urandom_range(0, 255), 1'b1);

    // backpressure with random ready
    rand_ready = 1'b1;
    start_row(40, $urandom_range(0, 255), 1'b1, 1'b0);
    wait_idle(2000);

    // zero-length start is ignored
    rand_ready = 1'b0;
    start_row(0, $urandom_range(0, 255), 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("zero_busy", EW'(busy), '0);
      check_val("zero_done", EW'(done), '0);
    end

    // start while busy is ignored
    rand_ready = 1'b1;
    start_row(40, $urandom_range(0, 255), 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    start_row(16, $urandom_range(0, 255), 1'b0, 1'b0);
    wait_idle(2000);

    // random rows
    for (int r = 0; r < 10; r++) begin
      start_row($urandom_range(1, 200), $urandom_range(0, 255), 1'b1, 1'b0);
      wait_idle(4000);
    end

    // reset in the middle of a 64-element row, at the third output word
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    start_row(64, $urandom_range(0, 255), 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    check_val("third_word_vld", EW'(bus.out_vld), EW'(8'hFF));
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_q.delete();
    addr_q.delete();
    issued   = 0;
    accepted = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_timed(64, $urandom_range(0, 255), 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule
